// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: FSM states, the queued request
// record and the multiply command codes that select the longer ALU latency.
package alu_pkg;

    // Widest operand the request record can carry; WIDTH must not exceed it.
    localparam int unsigned OPW_MAX = 32;

    localparam logic [3:0] CMD_MUL_A = 4'd9;
    localparam logic [3:0] CMD_MUL_B = 4'd10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        ISSUE_B = 3'd2,
        WAIT    = 3'd3,
        RESP    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [OPW_MAX-1:0] opa;
        logic [OPW_MAX-1:0] opb;
        logic [3:0]         cmd;
        logic               mode;
        logic               cin;
    } alu_req_t;

    function automatic logic is_mul(input alu_req_t r);
        return r.mode && ((r.cmd == CMD_MUL_A) || (r.cmd == CMD_MUL_B));
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Request FIFO for the ALU sequencer: power-of-two depth, registered count,
// simultaneous push and pop supported.
module alu_seq_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU requests and issues them one at a time to an external ALU,
// returning each result through a valid/ready response port.
// Define ALU_SEQ_SPLIT_EN to issue OPA and OPB on two consecutive cycles.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LAT     = 1,
    parameter int unsigned LAT_MUL = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_opa,
    input  logic [WIDTH-1:0]         req_opb,
    input  logic [3:0]               req_cmd,
    input  logic                     req_mode,
    input  logic                     req_cin,
    output logic [WIDTH-1:0]         ALU_OPA,
    output logic [WIDTH-1:0]         ALU_OPB,
    output logic [3:0]               ALU_CMD,
    output logic                     ALU_MODE,
    output logic                     ALU_CIN,
    output logic                     ALU_CE,
    output logic [1:0]               ALU_INP_VALID,
    input  logic [2*WIDTH-1:0]       ALU_RES,
    input  logic                     ALU_COUT,
    input  logic                     ALU_OFLOW,
    input  logic                     ALU_G,
    input  logic                     ALU_L,
    input  logic                     ALU_E,
    input  logic                     ALU_ERR,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_res,
    output logic [5:0]               rsp_flags,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output seq_state_t               dbg_state
);
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned LMAX = (LAT > LAT_MUL) ? LAT : LAT_MUL;
    localparam int unsigned LW   = $clog2(LMAX + 1);

    // Handshakes: a transfer happens on the rising CLK edge where valid and
    // ready are both high; valid, once raised, holds its payload until then.

    seq_state_t        state_q, state_d;
    alu_req_t          req_s, head, cur_q;
    logic [CW-1:0]     fifo_cnt;
    logic              push, pop;
    logic [LW-1:0]     lat_q;
    logic [2*WIDTH-1:0] rsp_res_q;
    logic [5:0]        rsp_flags_q;
    logic              unused_hi;

    always_comb begin
        req_s      = '0;
        req_s.opa  = OPW_MAX'(req_opa);
        req_s.opb  = OPW_MAX'(req_opb);
        req_s.cmd  = req_cmd;
        req_s.mode = req_mode;
        req_s.cin  = req_cin;
    end

    assign req_ready = !RST && (fifo_cnt < CW'(DEPTH));
    assign push      = req_valid && req_ready;

    alu_seq_fifo #(.W($bits(alu_req_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .data_i  (req_s),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        ALU_OPA       = '0;
        ALU_OPB       = '0;
        ALU_CMD       = '0;
        ALU_MODE      = 1'b0;
        ALU_CIN       = 1'b0;
        ALU_CE        = 1'b0;
        ALU_INP_VALID = 2'b00;
        case (state_q)
            IDLE: begin
                if (fifo_cnt != '0) state_d = ISSUE;
            end
            ISSUE: begin
                pop      = 1'b1;
                ALU_OPA  = head.opa[WIDTH-1:0];
                ALU_OPB  = head.opb[WIDTH-1:0];
                ALU_CMD  = head.cmd;
                ALU_MODE = head.mode;
                ALU_CIN  = head.cin;
                ALU_CE   = 1'b1;
`ifdef ALU_SEQ_SPLIT_EN
                ALU_INP_VALID = 2'b01;
                state_d       = ISSUE_B;
`else
                ALU_INP_VALID = 2'b11;
                state_d       = WAIT;
`endif
            end
`ifdef ALU_SEQ_SPLIT_EN
            ISSUE_B: begin
                ALU_OPA       = cur_q.opa[WIDTH-1:0];
                ALU_OPB       = cur_q.opb[WIDTH-1:0];
                ALU_CMD       = cur_q.cmd;
                ALU_MODE      = cur_q.mode;
                ALU_CIN       = cur_q.cin;
                ALU_CE        = 1'b1;
                ALU_INP_VALID = 2'b10;
                state_d       = WAIT;
            end
`endif
            WAIT: begin
                ALU_OPA  = cur_q.opa[WIDTH-1:0];
                ALU_OPB  = cur_q.opb[WIDTH-1:0];
                ALU_CMD  = cur_q.cmd;
                ALU_MODE = cur_q.mode;
                ALU_CIN  = cur_q.cin;
                ALU_CE   = 1'b1;
                if (lat_q == '0) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = (fifo_cnt != '0) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The latency count is loaded while the head is on the bus, so the split
    // second beat leaves it untouched and counting starts in WAIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            lat_q       <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ISSUE) begin
                cur_q <= head;
                lat_q <= is_mul(head) ? LW'(LAT_MUL - 1) : LW'(LAT - 1);
            end else if (state_q == WAIT) begin
                if (lat_q != '0) begin
                    lat_q <= lat_q - 1'b1;
                end else begin
                    rsp_res_q   <= ALU_RES;
                    rsp_flags_q <= {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E};
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != IDLE) || (fifo_cnt != '0);
    assign count     = fifo_cnt;
    assign dbg_state = state_q;

    assign unused_hi = ^{head.opa[OPW_MAX-1:WIDTH], head.opb[OPW_MAX-1:WIDTH],
                         cur_q.opa[OPW_MAX-1:WIDTH], cur_q.opb[OPW_MAX-1:WIDTH]};

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a latency-aware ALU stub.
// Build with ALU_SEQ_SPLIT_EN defined to exercise the two-beat issue.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_opa = '0;
    logic [7:0]  req_opb = '0;
    logic [3:0]  req_cmd = '0;
    logic        req_mode = 1'b0;
    logic        req_cin = 1'b0;
    logic [7:0]  ALU_OPA, ALU_OPB;
    logic [3:0]  ALU_CMD;
    logic        ALU_MODE, ALU_CIN, ALU_CE;
    logic [1:0]  ALU_INP_VALID;
    logic [15:0] ALU_RES;
    logic        ALU_COUT, ALU_OFLOW, ALU_G, ALU_L, ALU_E, ALU_ERR;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_res;
    logic [5:0]  rsp_flags;
    logic        busy;
    logic [2:0]  count;
    seq_state_t  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [21:0] exp_q[$];

    alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .LAT(1), .LAT_MUL(2)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_opa(req_opa), .req_opb(req_opb),
        .req_cmd(req_cmd), .req_mode(req_mode), .req_cin(req_cin),
        .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD), .ALU_MODE(ALU_MODE),
        .ALU_CIN(ALU_CIN), .ALU_CE(ALU_CE), .ALU_INP_VALID(ALU_INP_VALID),
        .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW), .ALU_G(ALU_G),
        .ALU_L(ALU_L), .ALU_E(ALU_E), .ALU_ERR(ALU_ERR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .busy(busy), .count(count), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ALU stub: result is only presented in the cycle where the sequencer
    // should sample it; any other cycle shows 16'hDEAD.
    logic [7:0] s_opa = '0, s_opb = '0;
    logic [3:0] s_cmd = '0;
    logic       s_mode = 1'b0, s_cin = 1'b0;
    int         s_age = 100;
    int         s_lat;
    logic [8:0] s_sum;

    always @(posedge CLK) begin
        if (ALU_INP_VALID[0]) begin
            s_opa  <= ALU_OPA;
            s_cmd  <= ALU_CMD;
            s_mode <= ALU_MODE;
            s_cin  <= ALU_CIN;
        end
        if (ALU_INP_VALID[1]) begin
            s_opb <= ALU_OPB;
            s_age <= 0;
        end else if (s_age < 100) begin
            s_age <= s_age + 1;
        end
    end

    always_comb begin
        s_lat     = (s_mode && (s_cmd == 4'd9 || s_cmd == 4'd10)) ? 2 : 1;
        s_sum     = {1'b0, s_opa} + {1'b0, s_opb} + {8'h00, s_cin};
        ALU_RES   = 16'hDEAD;
        ALU_COUT  = 1'b0;
        ALU_OFLOW = 1'b0;
        ALU_G     = 1'b0;
        ALU_L     = 1'b0;
        ALU_E     = 1'b0;
        ALU_ERR   = 1'b0;
        if (s_age == s_lat - 1) begin
            if (s_mode && s_cmd == 4'd0) begin
                ALU_RES  = {7'h00, s_sum};
                ALU_COUT = s_sum[8];
            end else if (s_mode && (s_cmd == 4'd9 || s_cmd == 4'd10)) begin
                ALU_RES = s_opa * s_opb;
            end else begin
                ALU_RES = 16'h0000;
                ALU_ERR = 1'b1;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                            input logic m, input logic ci);
        int n;
        req_opa   = a;
        req_opb   = b;
        req_cmd   = c;
        req_mode  = m;
        req_cin   = ci;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: req_ready stayed %b, required 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_state(input seq_state_t s, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (dbg_state == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Scenarios
    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", count); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        tests_run++; if ({rsp_flags, rsp_res} !== 22'h0) begin tests_failed++; $display("FAIL rst_rsp_data: got %h want 0", {rsp_flags, rsp_res}); end
        tests_run++; if ({ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CMD} !== 23'h0) begin tests_failed++; $display("FAIL rst_alu_out: got %h want 0", {ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CMD}); end
        tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
        RST = 1'b0;
        tick();
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b0;
        push_req(8'h05, 8'h03, 4'd0, 1'b1, 1'b0);
        tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", count); end
        tick();
        tests_run++; if (dbg_state !== ISSUE) begin tests_failed++; $display("FAIL single_issue_state: got %0d want ISSUE", dbg_state); end
        tests_run++; if ({ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CE} !== {8'h05, 8'h03, 4'd0, 1'b1, 1'b1}) begin tests_failed++; $display("FAIL single_issue_bus: got %h want %h", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CE}, {8'h05, 8'h03, 4'd0, 1'b1, 1'b1}); end
`ifdef ALU_SEQ_SPLIT_EN
        tests_run++; if (ALU_INP_VALID !== 2'b01) begin tests_failed++; $display("FAIL split_beat_a: got %b want 01", ALU_INP_VALID); end
        tick();
        tests_run++; if (ALU_INP_VALID !== 2'b10) begin tests_failed++; $display("FAIL split_beat_b: got %b want 10", ALU_INP_VALID); end
        tests_run++; if (ALU_OPB !== 8'h03) begin tests_failed++; $display("FAIL split_opb: got %h want 03", ALU_OPB); end
`else
        tests_run++; if (ALU_INP_VALID !== 2'b11) begin tests_failed++; $display("FAIL single_inp_valid: got %b want 11", ALU_INP_VALID); end
`endif
        tick();
        tests_run++; if ({dbg_state, ALU_CE, ALU_INP_VALID, ALU_OPA} !== {WAIT, 1'b1, 2'b00, 8'h05}) begin tests_failed++; $display("FAIL single_wait: got %h want %h", {dbg_state, ALU_CE, ALU_INP_VALID, ALU_OPA}, {WAIT, 1'b1, 2'b00, 8'h05}); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
        tick();
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        tests_run++; if ({rsp_flags, rsp_res} !== {6'h00, 16'h0008}) begin tests_failed++; $display("FAIL single_rsp_data: got %h want %h", {rsp_flags, rsp_res}, {6'h00, 16'h0008}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++; if ({rsp_valid, busy, dbg_state} !== {1'b0, 1'b0, IDLE}) begin tests_failed++; $display("FAIL single_done: got %h want %h", {rsp_valid, busy, dbg_state}, {1'b0, 1'b0, IDLE}); end
    endtask

    task automatic test_mul_latency();
        rsp_ready = 1'b0;
        push_req(8'd3, 8'd4, 4'd9, 1'b1, 1'b0);
        tick();
`ifdef ALU_SEQ_SPLIT_EN
        tick();
`endif
        tick();
        tests_run++; if ({dbg_state, rsp_valid} !== {WAIT, 1'b0}) begin tests_failed++; $display("FAIL mul_wait1: got %h want %h", {dbg_state, rsp_valid}, {WAIT, 1'b0}); end
        tick();
        tests_run++; if ({dbg_state, rsp_valid, ALU_CE} !== {WAIT, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL mul_wait2: got %h want %h", {dbg_state, rsp_valid, ALU_CE}, {WAIT, 1'b0, 1'b1}); end
        tick();
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL mul_rsp_valid: got %b want 1", rsp_valid); end
        tests_run++; if ({rsp_flags, rsp_res} !== {6'h00, 16'h000C}) begin tests_failed++; $display("FAIL mul_rsp_data: got %h want %h", {rsp_flags, rsp_res}, {6'h00, 16'h000C}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  got;
        bit  hs_prev;
        logic [21:0] exp;
        rsp_ready = 1'b0;
        exp_q.delete();
        push_req(8'h01, 8'h02, 4'd0,  1'b1, 1'b0); exp_q.push_back({6'h00, 16'h0003});
        push_req(8'h07, 8'h08, 4'd9,  1'b1, 1'b0); exp_q.push_back({6'h00, 16'h0038});
        push_req(8'hFF, 8'h01, 4'd0,  1'b1, 1'b0); exp_q.push_back({6'h08, 16'h0100});
        push_req(8'h05, 8'h05, 4'd15, 1'b1, 1'b0); exp_q.push_back({6'h20, 16'h0000});
        push_req(8'h10, 8'h10, 4'd10, 1'b1, 1'b0); exp_q.push_back({6'h00, 16'h0100});
        tests_run++; if ({req_ready, count} !== {1'b0, 3'd4}) begin tests_failed++; $display("FAIL b2b_full: got ready=%b count=%0d want ready=0 count=4", req_ready, count); end
        rsp_ready = 1'b1;
        got = 0;
        hs_prev = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            if (hs_prev) begin
                tests_run++; if (dbg_state !== ISSUE) begin tests_failed++; $display("FAIL b2b_no_idle: got state %0d want ISSUE", dbg_state); end
            end
            hs_prev = 1'b0;
            if (rsp_valid) begin
                exp = exp_q.pop_front();
                tests_run++; if ({rsp_flags, rsp_res} !== exp) begin tests_failed++; $display("FAIL b2b_rsp%0d: got %h want %h", got, {rsp_flags, rsp_res}, exp); end
                got++;
                hs_prev = (got < 5);
            end
            tick();
        end
        tests_run++; if (got !== 5) begin tests_failed++; $display("FAIL b2b_rsp_count: got %0d want 5", got); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_stall();
        bit ok;
        int got;
        logic [21:0] exp;
        rsp_ready = 1'b0;
        exp_q.delete();
        push_req(8'h11, 8'h22, 4'd0,  1'b1, 1'b0); exp_q.push_back({6'h00, 16'h0033});
        push_req(8'h02, 8'h03, 4'd9,  1'b1, 1'b0); exp_q.push_back({6'h00, 16'h0006});
        push_req(8'h80, 8'h80, 4'd0,  1'b1, 1'b1); exp_q.push_back({6'h08, 16'h0101});
        push_req(8'h01, 8'h01, 4'd15, 1'b1, 1'b0); exp_q.push_back({6'h20, 16'h0000});
        wait_state(RESP, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL stall_reach_resp: got state %0d want RESP", dbg_state); end
        for (int i = 0; i < 10; i++) begin
            tests_run++; if ({rsp_valid, rsp_flags, rsp_res} !== {1'b1, 6'h00, 16'h0033}) begin tests_failed++; $display("FAIL stall_hold%0d: got %h want %h", i, {rsp_valid, rsp_flags, rsp_res}, {1'b1, 6'h00, 16'h0033}); end
            tests_run++; if ({ALU_CE, ALU_INP_VALID, count} !== {1'b0, 2'b00, 3'd3}) begin tests_failed++; $display("FAIL stall_quiet%0d: got %h want %h", i, {ALU_CE, ALU_INP_VALID, count}, {1'b0, 2'b00, 3'd3}); end
            tick();
        end
        push_req(8'h04, 8'h04, 4'd10, 1'b1, 1'b0); exp_q.push_back({6'h00, 16'h0010});
        tests_run++; if ({req_ready, count} !== {1'b0, 3'd4}) begin tests_failed++; $display("FAIL stall_full: got ready=%b count=%0d want ready=0 count=4", req_ready, count); end
        rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            if (rsp_valid) begin
                exp = exp_q.pop_front();
                tests_run++; if ({rsp_flags, rsp_res} !== exp) begin tests_failed++; $display("FAIL stall_drain%0d: got %h want %h", got, {rsp_flags, rsp_res}, exp); end
                got++;
            end
            tick();
        end
        tests_run++; if ({got == 5, busy} !== 2'b10) begin tests_failed++; $display("FAIL stall_drain_done: got responses=%0d busy=%b want 5 and 0", got, busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        rsp_ready = 1'b0;
        push_req(8'h03, 8'h04, 4'd9, 1'b1, 1'b0);
        push_req(8'h01, 8'h01, 4'd0, 1'b1, 1'b0);
        push_req(8'h02, 8'h02, 4'd0, 1'b1, 1'b0);
        wait_state(WAIT, ok);
        tests_run++; if (!ok || count !== 3'd2) begin tests_failed++; $display("FAIL rmid_setup: got state %0d count %0d want WAIT and 2", dbg_state, count); end
        RST = 1'b1;
        tick();
        tests_run++; if ({rsp_valid, count, ALU_CE, ALU_INP_VALID} !== {1'b0, 3'd0, 1'b0, 2'b00}) begin tests_failed++; $display("FAIL rmid_flush: got %h want 0", {rsp_valid, count, ALU_CE, ALU_INP_VALID}); end
        tests_run++; if ({dbg_state, req_ready} !== {IDLE, 1'b0}) begin tests_failed++; $display("FAIL rmid_state: got %h want %h", {dbg_state, req_ready}, {IDLE, 1'b0}); end
        RST = 1'b0;
        tick();
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_ready_back: got %b want 1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if ({rsp_valid, busy, ALU_CE} !== 3'b000) begin tests_failed++; $display("FAIL rmid_discard%0d: got %b want 000", i, {rsp_valid, busy, ALU_CE}); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul_latency();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
